// File: rtl/bin2bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter with 7-segment output.
// The optional BIN2BCD_LZ_BLANK_EN build blanks leading zero digits; see bin2bcd_seq_disp.
package bin2bcd_pkg;

    localparam int SEG_W = 7;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Active-high segments, bit0 = a ... bit6 = g
    localparam logic [SEG_W-1:0] SEG_0     = 7'b0111111;
    localparam logic [SEG_W-1:0] SEG_1     = 7'b0000110;
    localparam logic [SEG_W-1:0] SEG_2     = 7'b1011011;
    localparam logic [SEG_W-1:0] SEG_3     = 7'b1001111;
    localparam logic [SEG_W-1:0] SEG_4     = 7'b1100110;
    localparam logic [SEG_W-1:0] SEG_5     = 7'b1101101;
    localparam logic [SEG_W-1:0] SEG_6     = 7'b1111101;
    localparam logic [SEG_W-1:0] SEG_7     = 7'b0000111;
    localparam logic [SEG_W-1:0] SEG_8     = 7'b1111111;
    localparam logic [SEG_W-1:0] SEG_9     = 7'b1100111;
    localparam logic [SEG_W-1:0] SEG_BLANK = 7'b0000000;

endpackage

// File: rtl/bin2bcd_seq_disp_seg7_decode.sv
// One BCD nibble to active-high 7-segment pattern; blank forces all segments off.
// Non-decimal codes (10..15) render as zero so a corrupted digit never lights garbage.
module seg7_decode
    import bin2bcd_pkg::*;
(
    input  logic [3:0]       nibble,
    input  logic             blank,
    output logic [SEG_W-1:0] seg
);

    always_comb begin
        seg = SEG_0;
        if (blank) begin
            seg = SEG_BLANK;
        end else begin
            case (nibble)
                4'd0:    seg = SEG_0;
                4'd1:    seg = SEG_1;
                4'd2:    seg = SEG_2;
                4'd3:    seg = SEG_3;
                4'd4:    seg = SEG_4;
                4'd5:    seg = SEG_5;
                4'd6:    seg = SEG_6;
                4'd7:    seg = SEG_7;
                4'd8:    seg = SEG_8;
                4'd9:    seg = SEG_9;
                default: seg = SEG_0;
            endcase
        end
    end

endmodule

// File: rtl/bin2bcd_seq_disp.sv
// Sequential double-dabble converter (one bit per clock) with registered BCD and per-digit 7-seg decode.
// Define BIN2BCD_LZ_BLANK_EN to blank leading zero digits on the display (digit 0 always shown).
module bin2bcd_seq_disp
    import bin2bcd_pkg::*;
#(
    parameter int BIN_W  = 10,
    parameter int DIGITS = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic [BIN_W-1:0]          bin,
    output logic                      busy,
    output logic                      valid,
    output logic [4*DIGITS-1:0]       bcd,
    output logic [SEG_W*DIGITS-1:0]   display,
    output logic                      overflow
);

    localparam int CNT_W = $clog2(BIN_W + 1);
    localparam int BCD_W = 4 * DIGITS;

    state_t             state_reg, state_next;
    logic [CNT_W-1:0]   cnt_reg,   cnt_next;
    logic [BIN_W-1:0]   shift_reg, shift_next;
    logic [BCD_W-1:0]   work_reg,  work_next;
    logic               acc_reg,   acc_next;
    logic [BCD_W-1:0]   bcd_reg,   bcd_next;
    logic               ovf_reg,   ovf_next;
    logic               valid_reg, valid_next;

    logic [BCD_W-1:0]   adj;
    logic [DIGITS-1:0]  blank;

    // Add-3 correction so each digit carries correctly on the following left shift
    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_adj
            assign adj[4*gi +: 4] = (work_reg[4*gi +: 4] > 4'd4) ?
                                    (work_reg[4*gi +: 4] + 4'd3) : work_reg[4*gi +: 4];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            shift_reg <= '0;
            work_reg  <= '0;
            acc_reg   <= 1'b0;
            bcd_reg   <= '0;
            ovf_reg   <= 1'b0;
            valid_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            shift_reg <= shift_next;
            work_reg  <= work_next;
            acc_reg   <= acc_next;
            bcd_reg   <= bcd_next;
            ovf_reg   <= ovf_next;
            valid_reg <= valid_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        shift_next = shift_reg;
        work_next  = work_reg;
        acc_next   = acc_reg;
        bcd_next   = bcd_reg;
        ovf_next   = ovf_reg;
        valid_next = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    shift_next = bin;
                    work_next  = '0;
                    acc_next   = 1'b0;
                    cnt_next   = CNT_W'(BIN_W);
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                // Bit leaving the top digit means the value no longer fits in DIGITS digits
                acc_next   = acc_reg | adj[BCD_W-1];
                work_next  = {adj[BCD_W-2:0], shift_reg[BIN_W-1]};
                shift_next = {shift_reg[BIN_W-2:0], 1'b0};
                cnt_next   = cnt_reg - 1'b1;
                if (cnt_reg == CNT_W'(1)) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                bcd_next   = work_reg;
                ovf_next   = acc_reg;
                valid_next = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign busy     = (state_reg != IDLE);
    assign valid    = valid_reg;
    assign bcd      = bcd_reg;
    assign overflow = ovf_reg;

`ifdef BIN2BCD_LZ_BLANK_EN
    // A digit is blanked when it and every digit above it are zero
    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_blank
            if (gi == 0) begin : g_first
                assign blank[gi] = 1'b0;
            end else begin : g_upper
                assign blank[gi] = ~|bcd_reg[BCD_W-1:4*gi];
            end
        end
    endgenerate
`else
    assign blank = '0;
`endif

    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_seg
            seg7_decode u_dec (
                .nibble (bcd_reg[4*gi +: 4]),
                .blank  (blank[gi]),
                .seg    (display[SEG_W*gi +: SEG_W])
            );
        end
    endgenerate

endmodule

// File: tb/tb_bin2bcd_seq_disp.sv
// Directed bench for bin2bcd_seq_disp: three instances (10b/4d, 10b/3d, 14b/5d) share clock, reset and start.
// Expected display values follow BIN2BCD_LZ_BLANK_EN when the bench is built with it.
module tb_bin2bcd_seq_disp;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [9:0]  bin0, bin1;
    logic [13:0] bin2;

    logic        busy0, valid0, ovf0;
    logic [15:0] bcd0;
    logic [27:0] display0;
    logic        busy1, valid1, ovf1;
    logic [11:0] bcd1;
    logic [20:0] display1;
    logic        busy2, valid2, ovf2;
    logic [19:0] bcd2;
    logic [34:0] display2;

    int checks = 0;
    int passes = 0;
    int fails  = 0;
    int edge_no, v0_edge, v1_edge, v2_edge, v0_cnt, busy0_cnt;

    localparam logic [27:0] DISP0_1023 = {7'b0000110, 7'b0111111, 7'b1011011, 7'b1001111};
    localparam logic [20:0] DISP1_999  = {7'b1100111, 7'b1100111, 7'b1100111};
`ifdef BIN2BCD_LZ_BLANK_EN
    localparam logic [27:0] DISP0_ZERO = {21'b0, 7'b0111111};
    localparam logic [27:0] DISP0_FIVE = {21'b0, 7'b1101101};
    localparam logic [34:0] DISP2_ZERO = {28'b0, 7'b0111111};
`else
    localparam logic [27:0] DISP0_ZERO = {7'b0111111, 7'b0111111, 7'b0111111, 7'b0111111};
    localparam logic [27:0] DISP0_FIVE = {7'b0111111, 7'b0111111, 7'b0111111, 7'b1101101};
    localparam logic [34:0] DISP2_ZERO = {7'b0111111, 7'b0111111, 7'b0111111, 7'b0111111, 7'b0111111};
`endif

    always #5 clk = ~clk;

    bin2bcd_seq_disp #(.BIN_W(10), .DIGITS(4)) u0 (
        .clk(clk), .rst_n(rst_n), .start(start), .bin(bin0), .busy(busy0),
        .valid(valid0), .bcd(bcd0), .display(display0), .overflow(ovf0)
    );
    bin2bcd_seq_disp #(.BIN_W(10), .DIGITS(3)) u1 (
        .clk(clk), .rst_n(rst_n), .start(start), .bin(bin1), .busy(busy1),
        .valid(valid1), .bcd(bcd1), .display(display1), .overflow(ovf1)
    );
    bin2bcd_seq_disp #(.BIN_W(14), .DIGITS(5)) u2 (
        .clk(clk), .rst_n(rst_n), .start(start), .bin(bin2), .busy(busy2),
        .valid(valid2), .bcd(bcd2), .display(display2), .overflow(ovf2)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
        $display("check %-12s observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic arm();
        edge_no   = -1;
        v0_edge   = -1;
        v1_edge   = -1;
        v2_edge   = -1;
        v0_cnt    = 0;
        busy0_cnt = 0;
    endtask

    // One rising edge, then sample everything on the following falling edge
    task automatic step();
        @(posedge clk);
        edge_no++;
        @(negedge clk);
        if (valid0) begin
            v0_cnt++;
            if (v0_edge < 0) v0_edge = edge_no;
        end
        if (valid1 && v1_edge < 0) v1_edge = edge_no;
        if (valid2 && v2_edge < 0) v2_edge = edge_no;
        if (busy0) busy0_cnt++;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b1;
        start = 1'b0;
        bin0  = '0;
        bin1  = '0;
        bin2  = '0;
        #2 rst_n = 1'b0;
        #1;
        // Reset acts without a clock edge
        check("rst_busy0",  64'(busy0), 64'd0);
        check("rst_valid0", 64'(valid0), 64'd0);
        check("rst_bcd0",   64'(bcd0), 64'd0);
        check("rst_ovf0",   64'(ovf0), 64'd0);
        check("rst_disp0",  64'(display0), 64'(DISP0_ZERO));
        check("rst_busy1",  64'(busy1), 64'd0);
        check("rst_busy2",  64'(busy2), 64'd0);
        check("rst_disp2",  64'(display2), 64'(DISP2_ZERO));
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Max values; bin altered after acceptance must not matter
        bin0 = 10'd1023; bin1 = 10'd999; bin2 = 14'd16383; start = 1'b1;
        arm();
        step();
        start = 1'b0; bin0 = 10'd0; bin1 = 10'd0; bin2 = 14'd0;
        steps(15);
        check("A_lat0",  64'(v0_edge), 64'd11);
        check("A_lat1",  64'(v1_edge), 64'd11);
        check("A_lat2",  64'(v2_edge), 64'd15);
        check("A_vcnt0", 64'(v0_cnt), 64'd1);
        check("A_busy0", 64'(busy0_cnt), 64'd11);
        check("A_bcd0",  64'(bcd0), 64'h1023);
        check("A_disp0", 64'(display0), 64'(DISP0_1023));
        check("A_ovf0",  64'(ovf0), 64'd0);
        check("A_bcd1",  64'(bcd1), 64'h999);
        check("A_ovf1",  64'(ovf1), 64'd0);
        check("A_disp1", 64'(display1), 64'(DISP1_999));
        check("A_bcd2",  64'(bcd2), 64'h16383);
        check("A_ovf2",  64'(ovf2), 64'd0);

        // Zero, and first value past 3-digit range
        bin0 = 10'd0; bin1 = 10'd1000; bin2 = 14'd0; start = 1'b1;
        arm();
        step();
        start = 1'b0;
        steps(15);
        check("B_vcnt0", 64'(v0_cnt), 64'd1);
        check("B_bcd0",  64'(bcd0), 64'h0);
        check("B_disp0", 64'(display0), 64'(DISP0_ZERO));
        check("B_bcd1",  64'(bcd1), 64'h000);
        check("B_ovf1",  64'(ovf1), 64'd1);
        check("B_bcd2",  64'(bcd2), 64'h0);
        check("B_disp2", 64'(display2), 64'(DISP2_ZERO));

        // Second start during SHIFT is dropped
        bin0 = 10'd5; start = 1'b1;
        arm();
        step();
        start = 1'b0;
        steps(3);
        bin0 = 10'd7; start = 1'b1;
        step();
        start = 1'b0;
        steps(11);
        check("C_vcnt0", 64'(v0_cnt), 64'd1);
        check("C_lat0",  64'(v0_edge), 64'd11);
        check("C_busy0", 64'(busy0_cnt), 64'd11);
        check("C_bcd0",  64'(bcd0), 64'h0005);
        check("C_disp0", 64'(display0), 64'(DISP0_FIVE));

        // Start in the IDLE cycle right after DONE
        bin0 = 10'd42; start = 1'b1;
        arm();
        step();
        start = 1'b0;
        steps(11);
        check("D_valid0", 64'(valid0), 64'd1);
        check("D_bcd0a",  64'(bcd0), 64'h0042);
        bin0 = 10'd99; start = 1'b1;
        arm();
        step();
        start = 1'b0;
        steps(15);
        check("D_lat0",  64'(v0_edge), 64'd11);
        check("D_bcd0b", 64'(bcd0), 64'h0099);
        check("D_ovf1",  64'(ovf1), 64'd1);

        // Abort mid-conversion by reset
        bin0 = 10'd512; start = 1'b1;
        arm();
        step();
        start = 1'b0;
        steps(5);
        check("E_busypre", 64'(busy0), 64'd1);
        rst_n = 1'b0;
        #1;
        check("E_busy0",  64'(busy0), 64'd0);
        check("E_valid0", 64'(valid0), 64'd0);
        check("E_bcd0",   64'(bcd0), 64'd0);
        check("E_ovf1",   64'(ovf1), 64'd0);
        check("E_disp0",  64'(display0), 64'(DISP0_ZERO));
        @(negedge clk);
        steps(3);
        rst_n = 1'b1;
        arm();
        steps(15);
        check("E_novalid", 64'(v0_cnt), 64'd0);
        check("E_bcdhold", 64'(bcd0), 64'd0);
        bin0 = 10'd37; start = 1'b1;
        arm();
        step();
        start = 1'b0;
        steps(15);
        check("E_lat0", 64'(v0_edge), 64'd11);
        check("E_bcd37", 64'(bcd0), 64'h0037);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
